// File: rtl/ctrl_update_queue_if.sv
// ============================================================================
// Module   : ctrl_update_queue_if
// Brief    : Handshake bundle between the execute control pipe, the control
//            update queue and the predictor/BTB update port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE_LOG
`define BRANCH_TYPE_LOG 2
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

interface ctrl_update_queue_if;
  // Resolved control instruction from execute, flush from retire
  logic                        exceptionFlag_i;
  logic                        exeCtrlValid_i;
  logic [`SIZE_PC-1:0]         exeCtrlPC_i;
  logic [`BRANCH_TYPE_LOG-1:0] exeCtrlType_i;
  logic [`SIZE_PC-1:0]         exeCtrlNPC_i;
  logic                        exeCtrlDir_i;
  logic [`SIZE_CTI_LOG-1:0]    exeCtiID_i;
  // Update port toward the predictor/BTB
  logic                        updReady_i;
  logic                        updValid_o;
  logic [`SIZE_PC-1:0]         updPC_o;
  logic [`BRANCH_TYPE_LOG-1:0] updType_o;
  logic [`SIZE_PC-1:0]         updNPC_o;
  logic                        updDir_o;
  logic [`SIZE_CTI_LOG-1:0]    updCtiID_o;
  // Status
  logic                        ctrlQueueStall_o;
  logic                        overflow_o;

  // Producer/consumer environment side
  modport master (
    output exceptionFlag_i, exeCtrlValid_i, exeCtrlPC_i, exeCtrlType_i,
           exeCtrlNPC_i, exeCtrlDir_i, exeCtiID_i, updReady_i,
    input  updValid_o, updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o,
           ctrlQueueStall_o, overflow_o
  );

  // Queue side
  modport slave (
    input  exceptionFlag_i, exeCtrlValid_i, exeCtrlPC_i, exeCtrlType_i,
           exeCtrlNPC_i, exeCtrlDir_i, exeCtiID_i, updReady_i,
    output updValid_o, updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o,
           ctrlQueueStall_o, overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_update_queue.sv
// ============================================================================
// Module   : ctrl_update_queue
// Brief    : In-order FIFO of resolved control instructions awaiting a
//            predictor/BTB update slot. Raises stall near full, flags dropped
//            writes with a sticky overflow, flushes on exception.
//            Optional macro CTRL_UPD_BYPASS_EN: empty-queue pass-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_update_queue #(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = DEPTH - 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  ctrl_update_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(STALL_THRESH);

  // Entry storage (not reset: contents are only observed through count)
  logic [`SIZE_PC-1:0]         pcMem   [DEPTH];
  logic [`BRANCH_TYPE_LOG-1:0] typeMem [DEPTH];
  logic [`SIZE_PC-1:0]         npcMem  [DEPTH];
  logic                        dirMem  [DEPTH];
  logic [`SIZE_CTI_LOG-1:0]    ctiMem  [DEPTH];

  logic [PTR_W-1:0] rRdPtr;
  logic [PTR_W-1:0] rWrPtr;
  logic [CNT_W-1:0] rCount;
  logic             rOverflow;

  // Last fields presented, replayed while nothing valid is on the port
  logic [`SIZE_PC-1:0]         rHoldPC;
  logic [`BRANCH_TYPE_LOG-1:0] rHoldType;
  logic [`SIZE_PC-1:0]         rHoldNPC;
  logic                        rHoldDir;
  logic [`SIZE_CTI_LOG-1:0]    rHoldCti;

  logic wHeadValid;
  logic wHasRoom;
  logic wBypassHit;
  logic wPopStored;
  logic wPushAcc;
  logic wDropWrite;

  assign wHeadValid = (rCount != '0);
  assign wHasRoom   = (rCount < CNT_DEPTH);

`ifdef CTRL_UPD_BYPASS_EN
  // Empty queue: the incoming instruction is shown on the port this cycle
  assign wBypassHit = !wHeadValid && bus.exeCtrlValid_i && !bus.exceptionFlag_i;
`else
  assign wBypassHit = 1'b0;
`endif

  // A pop only ever retires a stored entry; a bypassed one never enters
  assign wPopStored = wHeadValid && bus.updReady_i;
  // Flush drops the same-cycle write silently; a consumed bypass is not stored
  assign wPushAcc   = bus.exeCtrlValid_i && !bus.exceptionFlag_i &&
                      (wHasRoom || wPopStored) && !(wBypassHit && bus.updReady_i);
  assign wDropWrite = bus.exeCtrlValid_i && !bus.exceptionFlag_i &&
                      !wHasRoom && !wPopStored;

  assign bus.updValid_o       = wHeadValid || wBypassHit;
  assign bus.ctrlQueueStall_o = (rCount >= CNT_STALL);
  assign bus.overflow_o       = rOverflow;

  // Output field select: stored head, else bypassed input, else held value
  always_comb begin
    bus.updPC_o    = rHoldPC;
    bus.updType_o  = rHoldType;
    bus.updNPC_o   = rHoldNPC;
    bus.updDir_o   = rHoldDir;
    bus.updCtiID_o = rHoldCti;
    if (wHeadValid) begin
      bus.updPC_o    = pcMem[rRdPtr];
      bus.updType_o  = typeMem[rRdPtr];
      bus.updNPC_o   = npcMem[rRdPtr];
      bus.updDir_o   = dirMem[rRdPtr];
      bus.updCtiID_o = ctiMem[rRdPtr];
    end else if (wBypassHit) begin
      bus.updPC_o    = bus.exeCtrlPC_i;
      bus.updType_o  = bus.exeCtrlType_i;
      bus.updNPC_o   = bus.exeCtrlNPC_i;
      bus.updDir_o   = bus.exeCtrlDir_i;
      bus.updCtiID_o = bus.exeCtiID_i;
    end
  end

  // Write accepted entries at the tail
  always_ff @(posedge clk) begin
    if (!reset && wPushAcc) begin
      pcMem[rWrPtr]   <= bus.exeCtrlPC_i;
      typeMem[rWrPtr] <= bus.exeCtrlType_i;
      npcMem[rWrPtr]  <= bus.exeCtrlNPC_i;
      dirMem[rWrPtr]  <= bus.exeCtrlDir_i;
      ctiMem[rWrPtr]  <= bus.exeCtiID_i;
    end
  end

  // Pointer/count/overflow bookkeeping; reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rRdPtr    <= '0;
      rWrPtr    <= '0;
      rCount    <= '0;
      rOverflow <= 1'b0;
    end else if (bus.exceptionFlag_i) begin
      rRdPtr <= '0;
      rWrPtr <= '0;
      rCount <= '0;
    end else begin
      if (wPushAcc)   rWrPtr <= rWrPtr + PTR_W'(1);
      if (wPopStored) rRdPtr <= rRdPtr + PTR_W'(1);
      case ({wPushAcc, wPopStored})
        2'b10:   rCount <= rCount + CNT_W'(1);
        2'b01:   rCount <= rCount - CNT_W'(1);
        default: rCount <= rCount;
      endcase
      if (wDropWrite) rOverflow <= 1'b1;
    end
  end

  // Remember whatever was last presented as valid on the update port
  always_ff @(posedge clk) begin
    if (reset) begin
      rHoldPC   <= '0;
      rHoldType <= '0;
      rHoldNPC  <= '0;
      rHoldDir  <= 1'b0;
      rHoldCti  <= '0;
    end else if (bus.updValid_o) begin
      rHoldPC   <= bus.updPC_o;
      rHoldType <= bus.updType_o;
      rHoldNPC  <= bus.updNPC_o;
      rHoldDir  <= bus.updDir_o;
      rHoldCti  <= bus.updCtiID_o;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_update_queue.sv
// ============================================================================
// Module   : tb_ctrl_update_queue
// Brief    : Directed self-checking bench for ctrl_update_queue (DEPTH=8,
//            default build without bypass), scoreboard-ordered checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_update_queue;

  typedef struct {
    logic [`SIZE_PC-1:0]         pc;
    logic [`BRANCH_TYPE_LOG-1:0] typ;
    logic [`SIZE_PC-1:0]         npc;
    logic                        dir;
    logic [`SIZE_CTI_LOG-1:0]    cti;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic expOvf;
  ent_t sb[$];

  ctrl_update_queue_if bus ();

  ctrl_update_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mkEnt(input logic [`SIZE_PC-1:0] pc);
    ent_t e;
    e.pc  = pc;
    e.typ = pc[3:2];
    e.npc = pc + 32'h1000;
    e.dir = pc[2];
    e.cti = pc[5:2];
    return e;
  endfunction

  task automatic drive(input ent_t e);
    bus.exeCtrlValid_i = 1'b1;
    bus.exeCtrlPC_i    = e.pc;
    bus.exeCtrlType_i  = e.typ;
    bus.exeCtrlNPC_i   = e.npc;
    bus.exeCtrlDir_i   = e.dir;
    bus.exeCtiID_i     = e.cti;
  endtask

  // Check the presented head against the oldest scoreboard entry and retire it
  task automatic checkHead(input string tag);
    ent_t e;
    chk({tag, "_valid"}, 64'(bus.updValid_o), 64'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sbempty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"},  64'(bus.updPC_o),    64'(e.pc));
      chk({tag, "_npc"}, 64'(bus.updNPC_o),   64'(e.npc));
      chk({tag, "_typ"}, 64'(bus.updType_o),  64'(e.typ));
      chk({tag, "_dir"}, 64'(bus.updDir_o),   64'(e.dir));
      chk({tag, "_cti"}, 64'(bus.updCtiID_o), 64'(e.cti));
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    ent_t e;
    logic popNow;
    checks = 0;
    errors = 0;
    expOvf = 1'b0;
    reset  = 1'b1;
    bus.exceptionFlag_i = 1'b0;
    bus.exeCtrlValid_i  = 1'b0;
    bus.exeCtrlPC_i     = '0;
    bus.exeCtrlType_i   = '0;
    bus.exeCtrlNPC_i    = '0;
    bus.exeCtrlDir_i    = 1'b0;
    bus.exeCtiID_i      = '0;
    bus.updReady_i      = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.updValid_o), 64'(0));
    chk("rst_stall", 64'(bus.ctrlQueueStall_o), 64'(0));
    chk("rst_ovf",   64'(bus.overflow_o), 64'(0));

    // Single entry, one cycle latency, then empty
    e.pc = 32'h1000; e.npc = 32'h2000; e.dir = 1'b1; e.cti = 4'd3; e.typ = 2'd1;
    drive(e);
    bus.updReady_i = 1'b1;
    chk("single_pre_valid", 64'(bus.updValid_o), 64'(0));
    sb.push_back(e);
    step();
    bus.exeCtrlValid_i = 1'b0;
    checkHead("single");
    step();
    chk("single_after_valid", 64'(bus.updValid_o), 64'(0));

    // Fill with ready low; stall rises on the sixth push
    bus.updReady_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = mkEnt(32'h100 + 32'(4 * i));
      drive(e);
      sb.push_back(e);
      step();
      if (i == 4) chk("stall_at5", 64'(bus.ctrlQueueStall_o), 64'(0));
      if (i == 5) chk("stall_at6", 64'(bus.ctrlQueueStall_o), 64'(1));
    end
    chk("full_stall", 64'(bus.ctrlQueueStall_o), 64'(1));

    // Full queue: push together with pop is legal, no overflow
    e = mkEnt(32'h200);
    drive(e);
    bus.updReady_i = 1'b1;
    checkHead("fullpp");
    sb.push_back(e);
    step();
    chk("fullpp_ovf", 64'(bus.overflow_o), 64'(0));

    // Full queue, no pop: write dropped and overflow sticks
    bus.updReady_i = 1'b0;
    drive(mkEnt(32'h1FC));
    step();
    bus.exeCtrlValid_i = 1'b0;
    expOvf = 1'b1;
    chk("drop_ovf", 64'(bus.overflow_o), 64'(expOvf));

    // Drain in order; the dropped write must not appear
    bus.updReady_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkHead("drain");
      step();
    end
    chk("drain_empty", 64'(bus.updValid_o), 64'(0));
    chk("drain_stall", 64'(bus.ctrlQueueStall_o), 64'(0));
    chk("drain_ovf",   64'(bus.overflow_o), 64'(expOvf));

    // Five entries then flush with a concurrent push
    bus.updReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(mkEnt(32'h300 + 32'(4 * i)));
      step();
    end
    drive(mkEnt(32'h3F0));
    bus.exceptionFlag_i = 1'b1;
    step();
    bus.exceptionFlag_i = 1'b0;
    bus.exeCtrlValid_i  = 1'b0;
    chk("flush_valid", 64'(bus.updValid_o), 64'(0));
    chk("flush_stall", 64'(bus.ctrlQueueStall_o), 64'(0));
    chk("flush_ovf",   64'(bus.overflow_o), 64'(expOvf));

    // Streaming push/pop across pointer wrap with random ready
    for (int i = 0; i < 24; i++) begin
      bus.updReady_i = 1'($urandom_range(0, 1));
      popNow = bus.updReady_i && (sb.size() != 0);
      chk("stream_valid", 64'(bus.updValid_o), 64'(sb.size() != 0));
      if (popNow) checkHead("stream");
      if (i < 20 && (sb.size() < 8 || popNow)) begin
        e = mkEnt(32'h400 + 32'(4 * i));
        drive(e);
        sb.push_back(e);
      end else begin
        bus.exeCtrlValid_i = 1'b0;
      end
      step();
      chk("stream_bound", 64'(sb.size() <= 8), 64'(1));
    end
    bus.exeCtrlValid_i = 1'b0;
    bus.updReady_i = 1'b1;
    for (int i = 0; i < 16 && sb.size() != 0; i++) begin
      checkHead("stream_drain");
      step();
    end
    chk("stream_sb_empty", 64'(sb.size()), 64'(0));
    chk("stream_empty", 64'(bus.updValid_o), 64'(0));
    chk("stream_ovf",   64'(bus.overflow_o), 64'(expOvf));

    // Reset dominates flush and push with three entries held
    bus.updReady_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mkEnt(32'h500 + 32'(4 * i)));
      step();
    end
    drive(mkEnt(32'h5F0));
    bus.exceptionFlag_i = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.exceptionFlag_i = 1'b0;
    bus.exeCtrlValid_i  = 1'b0;
    expOvf = 1'b0;
    chk("rst2_valid", 64'(bus.updValid_o), 64'(0));
    chk("rst2_stall", 64'(bus.ctrlQueueStall_o), 64'(0));
    chk("rst2_ovf",   64'(bus.overflow_o), 64'(expOvf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_update_queue.md
CTRL_UPDATE_QUEUE -- requirements
Module: ctrl_update_queue

Interface
REQ-001 Parameter: DEPTH, default 8, queue entries; power of two, >=4.
REQ-002 Parameter: STALL_THRESH, default DEPTH-2, occupancy at which stall is raised.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 exceptionFlag_i  input  1  exception flush from retire.
REQ-006 exeCtrlValid_i  input  1  resolved control instruction presented this cycle.
REQ-007 exeCtrlPC_i  input  `SIZE_PC  PC of resolved control instruction.
REQ-008 exeCtrlType_i  input  `BRANCH_TYPE_LOG  branch type.
REQ-009 exeCtrlNPC_i  input  `SIZE_PC  resolved target.
REQ-010 exeCtrlDir_i  input  1  resolved direction, 1 = taken.
REQ-011 exeCtiID_i  input  `SIZE_CTI_LOG  CTI queue tag.
REQ-012 updReady_i  input  1  predictor/BTB update port accepts this cycle.
REQ-013 updValid_o  output  1  update entry presented.
REQ-014 updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o  output  widths as REQ-007..011  head entry fields.
REQ-015 ctrlQueueStall_o  output  1  backpressure to issue select for control pipe.
REQ-016 overflow_o  output  1  sticky error: a write was dropped.

Function
REQ-017 Circular FIFO, DEPTH entries; read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
REQ-018 Push when exeCtrlValid_i=1 and (count<DEPTH or pop in same cycle); entry captures all five fields.
REQ-019 Pop when updValid_o=1 and updReady_i=1; read pointer advances at clock edge.
REQ-020 updValid_o = (count!=0); update fields driven combinationally from head entry; base latency input->output = 1 cycle.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance; legal when full and when count=1.
REQ-022 Push while full without pop: write dropped, pointers/count unchanged, overflow_o set next cycle and held until reset.
REQ-023 ctrlQueueStall_o = (count >= STALL_THRESH), registered-state derived, no dependence on same-cycle inputs.
REQ-024 exceptionFlag_i=1: at next edge pointers and count cleared; same-cycle push dropped (not an overflow); same-cycle pop has no further effect; overflow_o unchanged.
REQ-025 Head fields, when updValid_o=0, hold last driven value (no X requirement on consumer).
REQ-026 Output order strictly equals push order; no reordering, no merging.

Reset
REQ-027 reset=1 at edge: pointers=0, count=0, overflow_o=0; hence updValid_o=0, ctrlQueueStall_o=0 from next cycle.
REQ-028 Reset dominates exceptionFlag_i, push and pop in same cycle; entry storage need not be cleared.
REQ-029 Reset mid-drain: in-flight head discarded; no pop counted.

Configuration
REQ-030 Macro CTRL_UPD_BYPASS_EN.
REQ-031 Defined: when count=0 and exeCtrlValid_i=1 and exceptionFlag_i=0, updValid_o=1 same cycle with input fields; if updReady_i=1 entry is not stored; if updReady_i=0 entry is stored as normal.
REQ-032 Not defined: no combinational input->output path; REQ-020 latency applies always.

Verification
REQ-033 Reset, then push PC=0x1000,NPC=0x2000,Dir=1,CtiID=3 with updReady_i=1 -> next cycle updValid_o=1 with those fields, following cycle updValid_o=0 (bypass off: cycle+1; bypass on: same cycle, never stored).
REQ-034 updReady_i=0, push 8 entries PCs 0x100..0x11C -> stall asserts after 6th push edge, count=8; 9th push -> overflow_o=1; release ready -> 8 pops in order 0x100..0x11C.
REQ-035 Full queue, push PC=0x200 with updReady_i=1 same cycle -> head 0x100 popped, 0x200 accepted at tail, overflow_o stays 0.
REQ-036 Queue with 5 entries, exceptionFlag_i=1 with concurrent push -> next cycle updValid_o=0, count=0, stall=0, overflow_o unchanged.
REQ-037 Continuous push+pop for 20 cycles across pointer wrap with random ready -> output sequence equals input sequence, no loss, count never exceeds DEPTH.
REQ-038 reset asserted with count=3, push and exceptionFlag_i active -> next cycle all outputs at reset values including overflow_o=0.
